// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes,
// funct codes, ALU and PC-source selects, plus the DECODE dispatch helper.
package mips_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQ    = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11,
    S_MULT   = 4'd12,
    S_MULTWB = 4'd13
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [OP_W-1:0] FN_ADD  = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB  = 6'b100010;
  localparam logic [OP_W-1:0] FN_AND  = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR   = 6'b100101;
  localparam logic [OP_W-1:0] FN_SLT  = 6'b101010;
  localparam logic [OP_W-1:0] FN_MULT = 6'b011000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  // Successor of DECODE; S_FETCH doubles as the "unsupported instruction" marker.
  function automatic state_e decode_next(input logic [OP_W-1:0] opcode,
                                         input logic [OP_W-1:0] funct);
    state_e nxt;
    nxt = S_FETCH;
    case (opcode)
      OP_LW, OP_SW:      nxt = S_MEMADR;
      OP_BEQ:            nxt = S_BEQ;
      OP_ADDI, OP_ADDIU: nxt = S_IMMEX;
      OP_J:              nxt = S_JUMP;
      OP_RTYPE: begin
        case (funct)
          FN_MULT:                                nxt = S_MULT;
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT:  nxt = S_RTEX;
          default:                                nxt = S_FETCH;
        endcase
      end
      default:           nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mips_mult_timer.sv
// Down-counter that times the MULT state: loaded on entry, counts to zero,
// flags the entry cycle and completion.
module mips_mult_timer #(
  parameter int unsigned MULT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic first_c,
  output logic done_c
);

  localparam int unsigned CNT_W = $clog2(MULT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MULT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter only holds LOAD_VAL on the first MULT cycle since it decrements every cycle after.
  assign first_c = (cnt_q == LOAD_VAL);
  assign done_c  = (cnt_q == '0);

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: Moore decode of the state register, with
// memory-ready handshaking and a timed MULT state.
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 4,
  parameter bit          MEM_WAIT_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  input  logic         zero,
  input  logic         mem_ready,
  output logic         pc_write,
  output logic         pc_write_cond,
  output logic         iord,
  output logic         mem_read,
  output logic         mem_write,
  output logic         ir_write,
  output logic         mem_to_reg,
  output logic         reg_dst,
  output logic         reg_write,
  output logic         alu_src_a,
  output logic         mult_start,
  output logic         illegal,
  output logic [1:0]   alu_src_b,
  output logic [1:0]   alu_op,
  output logic [1:0]   pc_source,
  output logic [3:0]   state
);

  state_e state_q, state_d;
  state_e decode_nxt_c;
  logic   mem_go_c;
  logic   timer_load_c, timer_dec_c, timer_first_c, timer_done_c;
  logic   unused_zero;

  // The branch-taken enable is formed outside this block from pc_write_cond & zero.
  assign unused_zero = zero;

  assign mem_go_c     = mem_ready | ~MEM_WAIT_EN;
  assign decode_nxt_c = decode_next(opcode, funct);
  assign state        = state_q;

  mips_mult_timer #(
    .MULT_CYCLES (MULT_CYCLES)
  ) u_mult_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load_c),
    .dec     (timer_dec_c),
    .first_c (timer_first_c),
    .done_c  (timer_done_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and state decode; every strobe is held low while reset is asserted.
  always_comb begin
    state_d       = state_q;
    timer_load_c  = 1'b0;
    timer_dec_c   = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    mult_start    = 1'b0;
    illegal       = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    pc_source     = PC_ALU;

    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          if (mem_go_c) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b    = SRCB_BR;
          illegal      = (decode_nxt_c == S_FETCH);
          timer_load_c = (decode_nxt_c == S_MULT);
          state_d      = decode_nxt_c;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          if (mem_go_c) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          if (mem_go_c) state_d = S_FETCH;
        end
        S_RTEX: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
          state_d   = S_RTWB;
        end
        S_RTWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          state_d   = S_FETCH;
        end
        S_BEQ: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PC_ALUOUT;
          state_d       = S_FETCH;
        end
        S_IMMEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_d   = S_IMMWB;
        end
        S_IMMWB: begin
          reg_write = 1'b1;
          state_d   = S_FETCH;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PC_JUMP;
          state_d   = S_FETCH;
        end
        S_MULT: begin
          alu_src_a   = 1'b1;
          timer_dec_c = 1'b1;
          mult_start  = timer_first_c;
          if (timer_done_c) state_d = S_MULTWB;
        end
        S_MULTWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          state_d   = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule
